// File: rtl/priv_1_13_trap_sequencer_if.sv
// Request/strobe bundle between the pipeline/privilege blocks (master) and the trap sequencer (slave).
interface priv_1_13_trap_sequencer_if #(
  parameter int NIRQ = 16
);
  logic            exc_req;
  logic [3:0]      exc_cause;
  logic [NIRQ-1:0] irq_pending;
  logic            mret_req;
  logic            sret_req;
  logic [1:0]      curr_priv;
  logic            mstatus_mie;
  logic            mstatus_sie;
  logic [NIRQ-1:0] mideleg;
  logic [15:0]     medeleg;
  logic            pipe_drained;

  logic            flush;
  logic            csr_commit;
  logic            commit_to_s;
  logic            commit_is_intr;
  logic [3:0]      commit_cause;
  logic            ret_commit;
  logic            ret_is_s;
  logic            redirect_valid;
  logic            busy;

  modport master (
    output exc_req, exc_cause, irq_pending, mret_req, sret_req, curr_priv,
           mstatus_mie, mstatus_sie, mideleg, medeleg, pipe_drained,
    input  flush, csr_commit, commit_to_s, commit_is_intr, commit_cause,
           ret_commit, ret_is_s, redirect_valid, busy
  );

  modport slave (
    input  exc_req, exc_cause, irq_pending, mret_req, sret_req, curr_priv,
           mstatus_mie, mstatus_sie, mideleg, medeleg, pipe_drained,
    output flush, csr_commit, commit_to_s, commit_is_intr, commit_cause,
           ret_commit, ret_is_s, redirect_valid, busy
  );
endinterface

// File: rtl/priv_1_13_trap_sequencer.sv
// Trap/xRET sequencer: arbitrate, drain pipeline, commit pulse, redirect pulse.
// Define TRAP_SEQ_S_DELEG_EN to enable S-mode delegation and sret.
//
// state    | meaning
// IDLE     | evaluating requests, all outputs 0
// DRAIN    | flush held until pipe_drained
// COMMIT   | one-cycle csr_commit or ret_commit
// REDIRECT | one-cycle redirect_valid, then back to IDLE
module priv_1_13_trap_sequencer #(
  parameter int NIRQ = 16
) (
  input  logic                        CLK,
  input  logic                        nRST,
  priv_1_13_trap_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIRECT} state_t;

  // Interrupt bits from lowest to highest priority; later hits overwrite earlier ones.
  localparam int IRQ_ORDER [6] = '{5, 1, 9, 7, 3, 11};

  state_t          state;
  logic            is_trap;

  logic [NIRQ-1:0] irq_deleg;
  logic [NIRQ-1:0] irq_en;
  logic [NIRQ-1:0] irq_elig;
  logic            m_ok;
  logic            s_ok;
  logic            sie;
  logic            exc_to_s;
  logic            sret_ok;
  logic            irq_hit;
  logic [3:0]      irq_sel;
  logic            irq_to_s;
  logic            unused_sig;

`ifdef TRAP_SEQ_S_DELEG_EN
  assign irq_deleg  = bus.mideleg;
  assign sie        = bus.mstatus_sie;
  assign exc_to_s   = bus.medeleg[bus.exc_cause] && (bus.curr_priv != 2'd3);
  assign sret_ok    = bus.sret_req;
  assign unused_sig = ^irq_elig;
`else
  assign irq_deleg  = '0;
  assign sie        = 1'b0;
  assign exc_to_s   = 1'b0;
  assign sret_ok    = 1'b0;
  assign unused_sig = ^{irq_elig, bus.mideleg, bus.medeleg, bus.mstatus_sie, bus.sret_req, sie};
`endif

  // S-targeted interrupts are never taken from M (or the reserved level 2).
  assign m_ok     = (bus.curr_priv != 2'd3) || bus.mstatus_mie;
  assign s_ok     = (bus.curr_priv == 2'd0) || ((bus.curr_priv == 2'd1) && sie);
  assign irq_en   = (irq_deleg & {NIRQ{s_ok}}) | (~irq_deleg & {NIRQ{m_ok}});
  assign irq_elig = bus.irq_pending & irq_en;

  always_comb begin
    irq_hit  = 1'b0;
    irq_sel  = '0;
    irq_to_s = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (IRQ_ORDER[k] < NIRQ && irq_elig[IRQ_ORDER[k]]) begin
        irq_hit  = 1'b1;
        irq_sel  = 4'(IRQ_ORDER[k]);
        irq_to_s = irq_deleg[IRQ_ORDER[k]];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state              <= IDLE;
      is_trap            <= 1'b0;
      bus.flush          <= 1'b0;
      bus.busy           <= 1'b0;
      bus.csr_commit     <= 1'b0;
      bus.ret_commit     <= 1'b0;
      bus.redirect_valid <= 1'b0;
      bus.commit_to_s    <= 1'b0;
      bus.commit_is_intr <= 1'b0;
      bus.commit_cause   <= '0;
      bus.ret_is_s       <= 1'b0;
    end else begin
      bus.csr_commit     <= 1'b0;
      bus.ret_commit     <= 1'b0;
      bus.redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.exc_req || irq_hit || bus.mret_req || sret_ok) begin
            state     <= DRAIN;
            bus.flush <= 1'b1;
            bus.busy  <= 1'b1;
          end
          if (bus.exc_req) begin
            is_trap            <= 1'b1;
            bus.commit_to_s    <= exc_to_s;
            bus.commit_is_intr <= 1'b0;
            bus.commit_cause   <= bus.exc_cause;
            bus.ret_is_s       <= 1'b0;
          end else if (irq_hit) begin
            is_trap            <= 1'b1;
            bus.commit_to_s    <= irq_to_s;
            bus.commit_is_intr <= 1'b1;
            bus.commit_cause   <= irq_sel;
            bus.ret_is_s       <= 1'b0;
          end else if (bus.mret_req || sret_ok) begin
            is_trap            <= 1'b0;
            bus.commit_to_s    <= 1'b0;
            bus.commit_is_intr <= 1'b0;
            bus.commit_cause   <= '0;
            bus.ret_is_s       <= !bus.mret_req;
          end
        end
        DRAIN: begin
          if (bus.pipe_drained) begin
            state          <= COMMIT;
            bus.csr_commit <= is_trap;
            bus.ret_commit <= !is_trap;
          end
        end
        COMMIT: begin
          state              <= REDIRECT;
          bus.redirect_valid <= 1'b1;
        end
        REDIRECT: begin
          state              <= IDLE;
          is_trap            <= 1'b0;
          bus.flush          <= 1'b0;
          bus.busy           <= 1'b0;
          bus.commit_to_s    <= 1'b0;
          bus.commit_is_intr <= 1'b0;
          bus.commit_cause   <= '0;
          bus.ret_is_s       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priv_1_13_trap_sequencer.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against an event-level model.
module tb_priv_1_13_trap_sequencer;
  localparam int NIRQ = 16;
`ifdef TRAP_SEQ_S_DELEG_EN
  localparam bit DELEG = 1'b1;
`else
  localparam bit DELEG = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  priv_1_13_trap_sequencer_if #(.NIRQ(NIRQ)) bus ();

  priv_1_13_trap_sequencer #(.NIRQ(NIRQ)) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int prio [6];

  // Event being serviced and how far along it is: 0 draining, 1 commit, 2 redirect.
  bit         m_active;
  int         m_stage;
  bit         m_trap, m_intr, m_to_s, m_sret;
  logic [3:0] m_cause;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void pick(output bit found, output bit trap, output bit intr,
                               output bit to_s, output bit sret, output logic [3:0] cause);
    bit d, en;
    int i;
    found = 0; trap = 0; intr = 0; to_s = 0; sret = 0; cause = '0;
    if (bus.exc_req) begin
      found = 1; trap = 1; cause = bus.exc_cause;
      to_s  = DELEG && bus.medeleg[bus.exc_cause] && (bus.curr_priv != 2'd3);
      return;
    end
    for (int k = 0; k < 6; k++) begin
      i = prio[k];
      if (bus.irq_pending[i]) begin
        d  = DELEG && bus.mideleg[i];
        en = d ? (bus.curr_priv == 2'd0 || (bus.curr_priv == 2'd1 && bus.mstatus_sie))
               : (bus.curr_priv != 2'd3 || bus.mstatus_mie);
        if (en) begin
          found = 1; trap = 1; intr = 1; to_s = d; cause = 4'(i);
          return;
        end
      end
    end
    if (bus.mret_req) begin
      found = 1;
      return;
    end
    if (DELEG && bus.sret_req) begin
      found = 1; sret = 1;
    end
  endfunction

  task automatic model_update();
    bit f, t, n, s, r;
    logic [3:0] c;
    if (!nRST) m_active = 0;
    else if (!m_active) begin
      pick(f, t, n, s, r, c);
      if (f) begin
        m_active = 1; m_stage = 0;
        m_trap = t; m_intr = n; m_to_s = s; m_sret = r; m_cause = c;
      end
    end else begin
      case (m_stage)
        0: if (bus.pipe_drained) m_stage = 1;
        1: m_stage = 2;
        default: m_active = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("busy", bus.busy, m_active);
    check("flush", bus.flush, m_active);
    check("csr_commit", bus.csr_commit, m_active && m_stage == 1 && m_trap);
    check("ret_commit", bus.ret_commit, m_active && m_stage == 1 && !m_trap);
    check("redirect_valid", bus.redirect_valid, m_active && m_stage == 2);
    check("commit_to_s", bus.commit_to_s, m_active && m_to_s);
    check("commit_is_intr", bus.commit_is_intr, m_active && m_intr);
    check("commit_cause", bus.commit_cause, m_active ? m_cause : 4'd0);
    check("ret_is_s", bus.ret_is_s, m_active && m_sret);
  endtask

  task automatic step(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge CLK);
      model_update();
      @(negedge CLK);
      check_outputs();
    end
  endtask

  task automatic clear_inputs();
    bus.exc_req = 0; bus.exc_cause = '0; bus.irq_pending = '0;
    bus.mret_req = 0; bus.sret_req = 0; bus.curr_priv = 2'd0;
    bus.mstatus_mie = 0; bus.mstatus_sie = 0; bus.mideleg = '0;
    bus.medeleg = '0; bus.pipe_drained = 1;
  endtask

  initial begin
    prio[0] = 11; prio[1] = 3; prio[2] = 7; prio[3] = 9; prio[4] = 1; prio[5] = 5;
    m_active = 0; m_stage = 0;
    m_trap = 0; m_intr = 0; m_to_s = 0; m_sret = 0; m_cause = '0;
    clear_inputs();
    nRST = 0;
    step(2);
    nRST = 1;
    step(1);

    // Delegated exception with the pipeline already drained.
    bus.exc_req = 1; bus.exc_cause = 4'd2; bus.medeleg = 16'h0004;
    step(1);
    clear_inputs();
    step(4);

    // Simultaneous exception, interrupt 11 and mret.
    bus.exc_req = 1; bus.exc_cause = 4'd5; bus.irq_pending[11] = 1; bus.mret_req = 1;
    step(1);
    bus.exc_req = 0;
    step(9);
    clear_inputs();
    step(2);

    // Interrupt masked in M, then enabled.
    bus.curr_priv = 2'd3; bus.irq_pending[7] = 1;
    step(3);
    bus.mstatus_mie = 1;
    step(1);
    clear_inputs();
    step(4);

    // Delegated interrupt 9 blocked in M, taken from U.
    bus.curr_priv = 2'd3; bus.mideleg[9] = 1; bus.irq_pending[9] = 1;
    step(3);
    bus.curr_priv = 2'd0;
    step(1);
    clear_inputs();
    step(4);

    // sret with a 5-cycle drain stall, then the same with reset mid-drain.
    bus.sret_req = 1; bus.pipe_drained = 0;
    step(1);
    bus.sret_req = 0;
    step(5);
    bus.pipe_drained = 1;
    step(4);
    bus.sret_req = 1; bus.pipe_drained = 0;
    step(1);
    bus.sret_req = 0;
    step(2);
    nRST = 0;
    step(1);
    nRST = 1; bus.pipe_drained = 1;
    step(3);

    // All-ones medeleg with a U-mode exception 8.
    bus.medeleg = 16'hffff; bus.exc_req = 1; bus.exc_cause = 4'd8;
    step(1);
    clear_inputs();
    step(4);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.exc_req      = ($urandom_range(0, 7) == 0);
      bus.exc_cause    = 4'($urandom);
      bus.irq_pending  = NIRQ'($urandom & $urandom);
      bus.mret_req     = ($urandom_range(0, 5) == 0);
      bus.sret_req     = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 6))
        0, 1:    bus.curr_priv = 2'd0;
        2, 3:    bus.curr_priv = 2'd1;
        6:       bus.curr_priv = 2'd2;
        default: bus.curr_priv = 2'd3;
      endcase
      bus.mstatus_mie  = 1'($urandom);
      bus.mstatus_sie  = 1'($urandom);
      bus.mideleg      = NIRQ'($urandom);
      bus.medeleg      = 16'($urandom);
      bus.pipe_drained = ($urandom_range(0, 9) < 7);
      nRST             = ($urandom_range(0, 49) != 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
